// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - JTAG initiator expanding TAP commands into TCK/TMS/TDI sequences
//
// Purpose: accepts TLR_RESET / SHIFT_IR / SHIFT_DR / IDLE commands over a
// valid/ready handshake, plays out the TMS/TDI bit pattern one TCK period
// per bit, captures TDO during shift periods and returns it as one response.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op              00 TLR_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
//   cmd_len             shift length, or Run-Test/Idle cycle count
//   cmd_data            TDI bits, LSB shifted first
//   rsp_valid           one-cycle completion pulse
//   rsp_data            captured TDO, bit i = i-th shifted bit
//   tck, tms, tdi, trst pins to the target TAP
//   tdo                 data from the target TAP
module jtag_master #(
  parameter int MAX_LEN = 32,
  parameter int HALF    = 2,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trst
);

  // One extra bit so header + length + trailer never overflows.
  localparam int PW = LEN_W + 1;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [1:0] OP_TLR  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [PW-1:0]      n_q, n_d;
  logic [PW-1:0]      total_q, total_d;
  logic [PW-1:0]      period_q, period_d;
  logic [CW-1:0]      half_q, half_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;

  // {tms, tdi} for period p of a command. Header/trailer periods drive TDI=0.
  function automatic logic [1:0] seq_bits(input logic [1:0] op, input logic [PW-1:0] n,
                                          input logic [PW-1:0] p, input logic [MAX_LEN-1:0] data);
    logic [PW-1:0] hdr;
    logic [PW-1:0] k;
    logic          m;
    logic          d;
    hdr = (op == OP_IR) ? PW'(4) : PW'(3);
    k   = p - hdr;
    m   = 1'b0;
    d   = 1'b0;
    case (op)
      OP_TLR:  m = (p != PW'(5));
      OP_IDLE: m = 1'b0;
      default: begin
        if (p < hdr) begin
          m = (p == '0) || ((op == OP_IR) && (p == PW'(1)));
        end else if (p < hdr + n) begin
          m = (k == n - PW'(1));
          d = |(data & (MAX_LEN'(1) << k));
        end else begin
          m = (p == hdr + n);
        end
      end
    endcase
    return {m, d};
  endfunction

  // Effective length and period count of the offered command.
  logic [PW-1:0] len_ext, eff_n, eff_total;
  always_comb begin
    len_ext = {1'b0, cmd_len};
    if (cmd_op == OP_IDLE)              eff_n = len_ext;
    else if (cmd_len == '0)             eff_n = PW'(1);
    else if (len_ext > PW'(MAX_LEN))    eff_n = PW'(MAX_LEN);
    else                                eff_n = len_ext;
    case (cmd_op)
      OP_TLR:  eff_total = PW'(6);
      OP_IR:   eff_total = eff_n + PW'(6);
      OP_DR:   eff_total = eff_n + PW'(5);
      default: eff_total = eff_n;
    endcase
  end

  // Shift-period decode of the period currently on the wire.
  logic [PW-1:0] hdr_cur, k_cur;
  logic          in_shift;
  always_comb begin
    hdr_cur  = (op_q == OP_IR) ? PW'(4) : PW'(3);
    k_cur    = period_q - hdr_cur;
    in_shift = ((op_q == OP_IR) || (op_q == OP_DR)) &&
               (period_q >= hdr_cur) && (period_q < hdr_cur + n_q);
  end

  logic accept;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    n_d        = n_q;
    total_d    = total_q;
    period_d   = period_q;
    half_d     = half_q;
    data_d     = data_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    tck_d      = tck_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    trst_d     = 1'b0;
    cmd_ready  = (state_q != S_RUN);
    rsp_valid  = (state_q == S_DONE);
    accept     = cmd_valid && cmd_ready;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d     = cmd_op;
          n_d      = eff_n;
          total_d  = eff_total;
          data_d   = cmd_data;
          cap_d    = '0;
          period_d = '0;
          half_d   = '0;
          tck_d    = 1'b0;
          if (eff_total == '0) begin
            // Zero-cycle IDLE: no TCK activity, respond next cycle.
            state_d    = S_DONE;
            rsp_data_d = '0;
          end else begin
            state_d        = S_RUN;
            {tms_d, tdi_d} = seq_bits(cmd_op, eff_n, '0, cmd_data);
          end
        end
      end
      S_RUN: begin
        if (half_q == CW'(HALF - 1)) begin
          half_d = '0;
          tck_d  = ~tck_q;
          if (!tck_q) begin
            // Rising edge: capture TDO for shift periods.
            if (in_shift) cap_d = cap_q | (MAX_LEN'(tdo) << k_cur);
          end else if (period_q == total_q - PW'(1)) begin
            state_d    = S_DONE;
            rsp_data_d = cap_q;
          end else begin
            // Falling edge: the only place TMS/TDI move mid-command.
            period_d       = period_q + PW'(1);
            {tms_d, tdi_d} = seq_bits(op_q, n_q, period_q + PW'(1), data_q);
          end
        end else begin
          half_d = half_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 2'b00;
      n_q        <= '0;
      total_q    <= '0;
      period_q   <= '0;
      half_q     <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      trst_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      n_q        <= n_d;
      total_q    <= total_d;
      period_q   <= period_d;
      half_q     <= half_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
      trst_q     <= trst_d;
    end
  end

  assign tck      = tck_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;
  assign trst     = trst_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - scoreboard bench for jtag_master with a TAP state model
module tb_jtag_master;

  localparam logic [1:0] OP_TLR  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, tdo, trst;

  logic        tdo_loop = 1'b0;
  logic        tdo_const = 1'b0;
  logic        loop_q = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rises = 0;
  int shir_cnt = 0;
  int upir_cnt = 0;

  typedef struct { logic [31:0] d; int lat; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  logic tms_log[$];
  logic tdi_log[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign tdo = tdo_loop ? loop_q : tdo_const;

  jtag_master #(.MAX_LEN(32), .HALF(2)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst(trst)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin log and loopback target, both on rising TCK.
  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    rises++;
    loop_q <= tdi;
  end

  // Standard 16-state TAP controller.
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_t;
  tap_t tap_st = TLR;
  tap_t tap_nx;
  always_comb begin
    tap_nx = tap_st;
    case (tap_st)
      TLR:   tap_nx = tms ? TLR   : RTI;
      RTI:   tap_nx = tms ? SELDR : RTI;
      SELDR: tap_nx = tms ? SELIR : CAPDR;
      CAPDR: tap_nx = tms ? EX1DR : SHDR;
      SHDR:  tap_nx = tms ? EX1DR : SHDR;
      EX1DR: tap_nx = tms ? UPDR  : PDR;
      PDR:   tap_nx = tms ? EX2DR : PDR;
      EX2DR: tap_nx = tms ? UPDR  : SHDR;
      UPDR:  tap_nx = tms ? SELDR : RTI;
      SELIR: tap_nx = tms ? TLR   : CAPIR;
      CAPIR: tap_nx = tms ? EX1IR : SHIR;
      SHIR:  tap_nx = tms ? EX1IR : SHIR;
      EX1IR: tap_nx = tms ? UPIR  : PIR;
      PIR:   tap_nx = tms ? EX2IR : PIR;
      EX2IR: tap_nx = tms ? UPIR  : SHIR;
      UPIR:  tap_nx = tms ? SELDR : RTI;
      default: tap_nx = TLR;
    endcase
  end
  always @(posedge tck or posedge trst) begin
    if (trst) tap_st <= TLR;
    else begin
      if (tap_st == SHIR) shir_cnt++;
      if (tap_nx == UPIR) upir_cnt++;
      tap_st <= tap_nx;
    end
  end

  // Monitor: pairs each response with its expectation and acceptance time.
  always @(negedge clock) begin : monitor
    exp_t e;
    int a;
    if (reset) acc_q.delete();
    else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 with data %0h expected no response", rsp_data);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.d));
          chk("rsp_latency", 64'(cyc - a), 64'(e.lat));
        end
      end
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    end
  end

  // Called at #1 after a rising clock edge; returns #1 after the acceptance edge.
  task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                      input logic [31:0] exp_d, input int lat, input bit push);
    int n;
    exp_t e;
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 500) begin @(negedge clock); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got cmd_ready=0 expected 1");
    end
    if (push) begin e.d = exp_d; e.lat = lat; exp_q.push_back(e); end
    @(posedge clock); #1;
    // Scramble the bus so the DUT must have latched it.
    cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len; cmd_data = ~data;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin @(posedge clock); #1; n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, exp_q.size());
    end
    @(posedge clock); #1;
  endtask

  task automatic chk_log(input string name, input int base, input int n,
                         input logic [63:0] exp_tms, input logic [63:0] exp_tdi);
    logic [63:0] vt, vd;
    vt = '0; vd = '0;
    chk({name, "_periods"}, 64'(tms_log.size() - base), 64'(n));
    for (int i = 0; i < 64 && base + i < tms_log.size(); i++) begin
      vt[i] = tms_log[base + i];
      vd[i] = tdi_log[base + i];
    end
    chk({name, "_tms"}, vt, exp_tms);
    chk({name, "_tdi"}, vd, exp_tdi);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int base, r0, s0, u0, n;
    bit ok;
    exp_t e;

    @(negedge clock);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_trst", 64'(trst), 64'd1);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("trst_held", 64'(trst), 64'd1);
    @(posedge clock); #1;
    chk("trst_cleared", 64'(trst), 64'd0);

    // TLR_RESET: 6 periods, 25 clocks.
    base = tms_log.size();
    send(OP_TLR, 6'd0, 32'h0, 32'h0, 25, 1'b1);
    wait_done("tlr");
    chk_log("tlr", base, 6, 64'h1F, 64'h0);
    chk("tlr_tap_rti", 64'(tap_st), 64'(RTI));

    // SHIFT_DR 8 bits of 0xA5, tdo tied high.
    tdo_const = 1'b1;
    base = tms_log.size();
    send(OP_DR, 6'd8, 32'h000000A5, 32'h000000FF, 53, 1'b1);
    wait_done("dr8");
    chk_log("dr8", base, 13, 64'hC01, 64'h528);
    chk("dr8_tap_rti", 64'(tap_st), 64'(RTI));
    repeat (5) @(posedge clock);
    #1 chk("dr8_rsp_held", 64'(rsp_data), 64'hFF);

    // Zero length is treated as one bit.
    base = tms_log.size();
    send(OP_DR, 6'd0, 32'hFFFFFFFF, 32'h00000001, 25, 1'b1);
    wait_done("dr0");
    chk_log("dr0", base, 6, 64'h19, 64'h8);

    // Length above MAX_LEN clamps to 32.
    base = tms_log.size();
    send(OP_DR, 6'd40, 32'h0, 32'hFFFFFFFF, 149, 1'b1);
    wait_done("dr40");
    chk("dr40_periods", 64'(tms_log.size() - base), 64'd37);

    // 32-bit loopback: response is the data delayed by one bit.
    tdo_loop = 1'b1;
    send(OP_DR, 6'd32, 32'hDEADBEEF, 32'hBD5B7DDE, 149, 1'b1);
    wait_done("loop");
    tdo_loop = 1'b0;

    // SHIFT_IR 4 bits of 0x3 through the TAP model.
    tdo_const = 1'b0;
    base = tms_log.size(); s0 = shir_cnt; u0 = upir_cnt;
    send(OP_IR, 6'd4, 32'h3, 32'h0, 41, 1'b1);
    wait_done("ir4");
    chk_log("ir4", base, 10, 64'h183, 64'h30);
    chk("ir4_shift_edges", 64'(shir_cnt - s0), 64'd4);
    chk("ir4_updateir", 64'(upir_cnt - u0), 64'd1);
    chk("ir4_tap_rti", 64'(tap_st), 64'(RTI));

    // IDLE 3 cycles in Run-Test/Idle.
    base = tms_log.size();
    send(OP_IDLE, 6'd3, 32'hFFFFFFFF, 32'h0, 13, 1'b1);
    wait_done("idle3");
    chk_log("idle3", base, 3, 64'h0, 64'h0);

    // Handshake: second command held valid during the first.
    tdo_const = 1'b1;
    send(OP_DR, 6'd2, 32'h3, 32'h3, 29, 1'b1);
    cmd_op = OP_IDLE; cmd_len = 6'd0; cmd_data = 32'h0; cmd_valid = 1'b1;
    ok = 1'b1; n = 0;
    @(negedge clock);
    while (!rsp_valid && n < 200) begin
      if (cmd_ready) ok = 1'b0;
      @(negedge clock); n++;
    end
    chk("hs_ready_low", 64'(ok), 64'd1);
    chk("hs_rsp_seen", 64'(rsp_valid), 64'd1);
    chk("hs_ready_in_rsp", 64'(cmd_ready), 64'd1);
    e.d = 32'h0; e.lat = 1; exp_q.push_back(e);
    r0 = rises;
    @(posedge clock); #1 cmd_valid = 1'b0;
    wait_done("hs");
    chk("idle0_no_tck", 64'(rises - r0), 64'd0);

    // Asynchronous reset in the middle of a SHIFT_DR.
    send(OP_DR, 6'd16, 32'h1234, 32'h0, 0, 1'b0);
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_trst", 64'(trst), 64'd1);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    send(OP_TLR, 6'd0, 32'h0, 32'h0, 25, 1'b1);
    wait_done("tlr2");
    chk("tlr2_tap_rti", 64'(tap_st), 64'(RTI));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
